// File: rtl/multdiv.sv
// Multi-cycle signed 32-bit multiply/divide unit. One shared 33-bit adder runs
// shift-add multiplication or restoring division on operand magnitudes.
module multdiv (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_hi;        // product high half / partial remainder
    logic [31:0] r_lo;        // multiplier then product low half / dividend then quotient
    logic [31:0] r_op2;       // multiplicand or divisor magnitude
    logic [4:0]  r_cnt;
    logic        r_sign;
    logic        r_is_div;
    logic        r_div0;
    logic [31:0] r_result;
    logic        r_exception;

    logic        w_start;
    logic        w_start_div;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_add_a;
    logic [32:0] w_sum;
    logic [32:0] w_mul_acc;
    logic [63:0] w_prod;
    logic [31:0] w_neg_lo;
    logic [31:0] w_fix_result;
    logic        w_fix_exc;

    assign w_start     = ((r_state == IDLE) || (r_state == DONE)) && (ctrl_MULT || ctrl_DIV);
    assign w_start_div = ctrl_DIV && !ctrl_MULT;
    assign w_abs_a     = data_operandA[31] ? -data_operandA : data_operandA;
    assign w_abs_b     = data_operandB[31] ? -data_operandB : data_operandB;

    // Divide presents the left-shifted remainder and subtracts; multiply adds.
    assign w_add_a   = r_is_div ? {1'b0, r_hi[30:0], r_lo[31]} : {1'b0, r_hi};
    assign w_sum     = r_is_div ? (w_add_a - {1'b0, r_op2}) : (w_add_a + {1'b0, r_op2});
    assign w_mul_acc = r_lo[0] ? w_sum : {1'b0, r_hi};

    // Low word of -P equals -(P[31:0]), so one 32-bit negate serves both ops.
    assign w_prod   = {r_hi, r_lo};
    assign w_neg_lo = -r_lo;

    always_comb begin
        w_fix_result = r_sign ? w_neg_lo : r_lo;
        w_fix_exc    = 1'b0;
        if (r_is_div) begin
            if (r_div0) begin
                w_fix_result = 32'h0000_0000;
                w_fix_exc    = 1'b1;
            end else begin
                w_fix_exc = !r_sign && r_lo[31];
            end
        end else begin
            w_fix_exc = r_sign ? (w_prod > 64'h0000_0000_8000_0000)
                               : (w_prod >= 64'h0000_0000_8000_0000);
        end
    end

    // NOTE: next-state logic gets a default first so no path infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_start)
                    w_next = (w_start_div && (data_operandB == 32'h0)) ? FIX : RUN;
                else
                    w_next = IDLE;
            end
            RUN:     if (r_cnt == 5'd31) w_next = FIX;
            FIX:     w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hi        <= '0;
            r_lo        <= '0;
            r_op2       <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_is_div    <= 1'b0;
            r_div0      <= 1'b0;
            r_result    <= '0;
            r_exception <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_is_div <= w_start_div;
                        r_sign   <= data_operandA[31] ^ data_operandB[31];
                        r_div0   <= w_start_div && (data_operandB == 32'h0);
                        r_cnt    <= '0;
                        r_hi     <= '0;
                        r_lo     <= w_start_div ? w_abs_a : w_abs_b;
                        r_op2    <= w_start_div ? w_abs_b : w_abs_a;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_is_div) begin
                        r_hi <= w_sum[32] ? w_add_a[31:0] : w_sum[31:0];
                        r_lo <= {r_lo[30:0], ~w_sum[32]};
                    end else begin
                        r_hi <= w_mul_acc[32:1];
                        r_lo <= {w_mul_acc[0], r_lo[31:1]};
                    end
                end
                FIX: begin
                    r_result    <= w_fix_result;
                    r_exception <= w_fix_exc;
                end
                default: ;
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exception;
    assign data_resultRDY = (r_state == DONE);

endmodule
